// File: rtl/fpu_buffer_dma_if.sv
// fpu_buffer_dma_if: request, buffer-port and memory-port bundle for fpu_buffer_dma.
//   slave  : DMA side (takes requests, drives buffer ports and memory commands)
//   master : controller/buffer/memory side
//   i_req_*, i_*_address, i_*_stride, i_rd_buffer_sel : request from controller
//   o_making_request, o_buf_sel                        : status
//   o_rbuf_*                                           : read-buffer write port
//   o_wbuf_*, i_wbuf_rdata                             : write-buffer read port
//   o_mem_*, i_mem_rdata, i_mem_ack                    : memory command port
interface fpu_buffer_dma_if #(
    parameter int COL_WIDTH        = 10,
    parameter int MEM_BUFFER_WIDTH = 512,
    parameter int BEAT_BYTES       = 64
);
    localparam int BEATS = MEM_BUFFER_WIDTH / BEAT_BYTES;
    localparam int RW    = (COL_WIDTH > 1) ? $clog2(COL_WIDTH) : 1;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int DW    = BEAT_BYTES * 8;
    logic                  i_req_read;
    logic                  i_req_write;
    logic [31:0]           i_read_address;
    logic [31:0]           i_write_address;
    logic [31:0]           i_rd_stride;
    logic [31:0]           i_wr_stride;
    logic [15:0]           i_req_width;
    logic [7:0]            i_req_height;
    logic                  i_rd_buffer_sel;
    logic                  o_making_request;
    logic                  o_buf_sel;
    logic                  o_rbuf_wr_en;
    logic [RW-1:0]         o_rbuf_row;
    logic [BW-1:0]         o_rbuf_beat;
    logic [DW-1:0]         o_rbuf_wdata;
    logic                  o_wbuf_rd_en;
    logic [RW-1:0]         o_wbuf_row;
    logic [BW-1:0]         o_wbuf_beat;
    logic [DW-1:0]         i_wbuf_rdata;
    logic                  o_mem_rd;
    logic                  o_mem_wr;
    logic [31:0]           o_mem_addr;
    logic [DW-1:0]         o_mem_wdata;
    logic [BEAT_BYTES-1:0] o_mem_be;
    logic [DW-1:0]         i_mem_rdata;
    logic                  i_mem_ack;
    modport slave (
        input  i_req_read, i_req_write, i_read_address, i_write_address, i_rd_stride, i_wr_stride,
               i_req_width, i_req_height, i_rd_buffer_sel, i_wbuf_rdata, i_mem_rdata, i_mem_ack,
        output o_making_request, o_buf_sel, o_rbuf_wr_en, o_rbuf_row, o_rbuf_beat, o_rbuf_wdata,
               o_wbuf_rd_en, o_wbuf_row, o_wbuf_beat, o_mem_rd, o_mem_wr, o_mem_addr, o_mem_wdata, o_mem_be
    );
    modport master (
        output i_req_read, i_req_write, i_read_address, i_write_address, i_rd_stride, i_wr_stride,
               i_req_width, i_req_height, i_rd_buffer_sel, i_wbuf_rdata, i_mem_rdata, i_mem_ack,
        input  o_making_request, o_buf_sel, o_rbuf_wr_en, o_rbuf_row, o_rbuf_beat, o_rbuf_wdata,
               o_wbuf_rd_en, o_wbuf_row, o_wbuf_beat, o_mem_rd, o_mem_wr, o_mem_addr, o_mem_wdata, o_mem_be
    );
endinterface

// File: rtl/fpu_buffer_dma.sv
// fpu_buffer_dma: fills the inactive read buffer from memory and drains the inactive write buffer to memory.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   bus     : fpu_buffer_dma_if.slave (requests, buffer ports, memory port)
module fpu_buffer_dma #(
    parameter int COL_WIDTH        = 10,
    parameter int MEM_BUFFER_WIDTH = 512,
    parameter int BEAT_BYTES       = 64
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    fpu_buffer_dma_if.slave bus
);
    localparam int BEATS = MEM_BUFFER_WIDTH / BEAT_BYTES;
    localparam int RW    = (COL_WIDTH > 1) ? $clog2(COL_WIDTH) : 1;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int DW    = BEAT_BYTES * 8;
    typedef enum logic [2:0] {IDLE, WR_FETCH, WR_MEM, RD_MEM, DONE} state_t;
    state_t                r_state, w_next;
    logic                  r_req_read, r_buf_sel, r_wfirst;
    logic [31:0]           r_rd_addr, r_rd_stride, r_wr_stride, r_row_base, r_addr;
    logic [RW-1:0]         r_row, r_wrow_last;
    logic [BW-1:0]         r_beat, r_wbeat_last;
    logic [BEAT_BYTES-1:0] r_last_be, w_last_be;
    logic [DW-1:0]         r_wdata;
    logic [15:0]           w_width, w_rem;
    logic [7:0]            w_height;
    logic [16:0]           w_beats;
    logic [31:0]           w_stride;
    logic                  w_go_wr, w_accept, w_wr_phase, w_ack, w_last_beat, w_last_row, w_last;
    assign w_width     = (bus.i_req_width > 16'(MEM_BUFFER_WIDTH)) ? 16'(MEM_BUFFER_WIDTH) : bus.i_req_width;
    assign w_height    = (bus.i_req_height > 8'(COL_WIDTH)) ? 8'(COL_WIDTH) : bus.i_req_height;
    assign w_beats     = (17'(w_width) + 17'(BEAT_BYTES - 1)) / 17'(BEAT_BYTES);
    assign w_rem       = w_width % 16'(BEAT_BYTES);
    // partial last beat keeps only the low w_rem byte lanes
    assign w_last_be   = (w_rem == 16'd0) ? '1 : ~({BEAT_BYTES{1'b1}} << w_rem);
    assign w_go_wr     = bus.i_req_write && (w_width != 16'd0) && (w_height != 8'd0);
    assign w_accept    = (r_state == IDLE) && (bus.i_req_read || bus.i_req_write);
    assign w_wr_phase  = r_state == WR_MEM;
    // acks are only meaningful while a command is outstanding
    assign w_ack       = bus.i_mem_ack && (w_wr_phase || r_state == RD_MEM);
    assign w_last_beat = r_beat == (w_wr_phase ? r_wbeat_last : BW'(BEATS - 1));
    assign w_last_row  = r_row == (w_wr_phase ? r_wrow_last : RW'(COL_WIDTH - 1));
    assign w_last      = w_last_beat && w_last_row;
    assign w_stride    = w_wr_phase ? r_wr_stride : r_rd_stride;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (bus.i_req_read || bus.i_req_write)
                          w_next = w_go_wr ? WR_FETCH : bus.i_req_read ? RD_MEM : DONE;
            WR_FETCH: w_next = WR_MEM;
            WR_MEM:   if (w_ack) w_next = !w_last ? WR_FETCH : r_req_read ? RD_MEM : DONE;
            RD_MEM:   if (w_ack && w_last) w_next = DONE;
            default:  w_next = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_req_read   <= 1'b0;
            r_buf_sel    <= 1'b0;
            r_wfirst     <= 1'b0;
            r_rd_addr    <= '0;
            r_rd_stride  <= '0;
            r_wr_stride  <= '0;
            r_row_base   <= '0;
            r_addr       <= '0;
            r_row        <= '0;
            r_beat       <= '0;
            r_wrow_last  <= '0;
            r_wbeat_last <= '0;
            r_last_be    <= '0;
            r_wdata      <= '0;
        end else begin
            if (w_accept) begin
                r_req_read   <= bus.i_req_read;
                r_buf_sel    <= ~bus.i_rd_buffer_sel;
                r_rd_addr    <= bus.i_read_address;
                r_rd_stride  <= bus.i_rd_stride;
                r_wr_stride  <= bus.i_wr_stride;
                r_wrow_last  <= RW'(w_height - 8'd1);
                r_wbeat_last <= BW'(w_beats - 17'd1);
                r_last_be    <= w_last_be;
                r_row        <= '0;
                r_beat       <= '0;
                r_row_base   <= w_go_wr ? bus.i_write_address : bus.i_read_address;
                r_addr       <= w_go_wr ? bus.i_write_address : bus.i_read_address;
            end
            if (r_state == WR_FETCH) r_wfirst <= 1'b1;
            // buffer data arrives in the first WR_MEM cycle; hold it for the rest of the wait
            if (w_wr_phase) begin
                r_wfirst <= 1'b0;
                if (r_wfirst) r_wdata <= bus.i_wbuf_rdata;
            end
            if (w_ack) begin
                if (w_wr_phase && w_last) begin
                    r_row      <= '0;
                    r_beat     <= '0;
                    r_row_base <= r_rd_addr;
                    r_addr     <= r_rd_addr;
                end else if (w_last_beat) begin
                    r_row      <= r_row + 1'b1;
                    r_beat     <= '0;
                    r_row_base <= r_row_base + w_stride;
                    r_addr     <= r_row_base + w_stride;
                end else begin
                    r_beat     <= r_beat + 1'b1;
                    r_addr     <= r_addr + 32'(BEAT_BYTES);
                end
            end
        end
    end
    always_comb begin
        bus.o_making_request = (r_state == WR_FETCH) || (r_state == WR_MEM) || (r_state == RD_MEM);
        bus.o_buf_sel        = r_buf_sel;
        bus.o_mem_rd         = r_state == RD_MEM;
        bus.o_mem_wr         = w_wr_phase;
        bus.o_mem_addr       = r_addr;
        bus.o_mem_wdata      = !w_wr_phase ? '0 : r_wfirst ? bus.i_wbuf_rdata : r_wdata;
        bus.o_mem_be         = !w_wr_phase ? '0 : w_last_beat ? r_last_be : '1;
        bus.o_rbuf_wr_en     = (r_state == RD_MEM) && bus.i_mem_ack;
        bus.o_rbuf_row       = r_row;
        bus.o_rbuf_beat      = r_beat;
        bus.o_rbuf_wdata     = ((r_state == RD_MEM) && bus.i_mem_ack) ? bus.i_mem_rdata : '0;
        bus.o_wbuf_rd_en     = r_state == WR_FETCH;
        bus.o_wbuf_row       = r_row;
        bus.o_wbuf_beat      = r_beat;
    end
endmodule

// File: tb/tb_fpu_buffer_dma.sv
// tb_fpu_buffer_dma: scoreboard bench with a randomized memory/buffer model for fpu_buffer_dma.
module tb_fpu_buffer_dma;
    typedef struct {bit wr; logic [31:0] addr; logic [511:0] data; logic [63:0] be;} mtx_t;
    typedef struct {logic [3:0] row; logic [2:0] beat; logic [511:0] data;} rtx_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    fpu_buffer_dma_if ifc();
    fpu_buffer_dma dut (.i_clk(clk), .i_rst_n(rst_n), .bus(ifc.slave));
    always #5 clk = ~clk;
    int vectors = 0, miscompares = 0, max_wait = 0, busy_cnt = 0, wl = 0;
    bit pend = 0, stray = 0, held = 0, cmd = 0;
    mtx_t mq[$];
    rtx_t rq[$];
    mtx_t mm;
    rtx_t rr;
    logic [511:0] wbuf [2][10][8];
    logic h_rd, h_wr;
    logic [31:0] h_addr;
    logic [511:0] h_wdata;
    logic [63:0] h_be;
    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    function automatic logic [511:0] rd_word(input logic [31:0] a);
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = (a ^ 32'hA5C3_96E1) * 32'h9E37_79B1 + 32'(i);
        return d;
    endfunction
    function automatic logic [511:0] rnd512();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction
    function automatic logic [511:0] bmask(input logic [63:0] be);
        logic [511:0] m;
        for (int i = 0; i < 64; i++) m[i*8 +: 8] = {8{be[i]}};
        return m;
    endfunction
    // write buffer: registered read, garbage on cycles with no read
    always @(posedge clk)
        ifc.i_wbuf_rdata <= ifc.o_wbuf_rd_en ? wbuf[ifc.o_buf_sel][ifc.o_wbuf_row][ifc.o_wbuf_beat] : rnd512();
    // memory responder: random wait per command, optional stray acks when idle
    always @(negedge clk) begin
        if (!rst_n) begin
            ifc.i_mem_ack = 1'b0;
            ifc.i_mem_rdata = '0;
            pend = 0;
        end else if (ifc.o_mem_rd || ifc.o_mem_wr) begin
            if (!pend) begin
                pend = 1;
                wl = $urandom_range(0, max_wait);
            end
            if (wl == 0) begin
                ifc.i_mem_ack = 1'b1;
                ifc.i_mem_rdata = rd_word(ifc.o_mem_addr);
                pend = 0;
            end else begin
                ifc.i_mem_ack = 1'b0;
                wl--;
            end
        end else begin
            pend = 0;
            ifc.i_mem_ack = stray && ($urandom_range(0, 3) == 0);
            ifc.i_mem_rdata = rnd512();
        end
    end
    // monitor: samples just before each rising edge
    initial forever begin
        @(negedge clk);
        #4;
        if (!rst_n) held = 0;
        else begin
            cmd = ifc.o_mem_rd | ifc.o_mem_wr;
            if (cmd) chk("rd_wr_exclusive", 512'(ifc.o_mem_rd & ifc.o_mem_wr), 512'(0));
            if (held) begin
                chk("hold_cmd", 512'({ifc.o_mem_rd, ifc.o_mem_wr}), 512'({h_rd, h_wr}));
                chk("hold_addr", 512'(ifc.o_mem_addr), 512'(h_addr));
                chk("hold_wdata", ifc.o_mem_wdata, h_wdata);
                chk("hold_be", 512'(ifc.o_mem_be), 512'(h_be));
            end
            if (cmd && ifc.i_mem_ack) begin
                held = 0;
                if (mq.size() == 0) chk("mem_unexpected", 512'(mq.size()), 512'(1));
                else begin
                    mm = mq.pop_front();
                    chk("mem_dir", 512'(ifc.o_mem_wr), 512'(mm.wr));
                    chk("mem_addr", 512'(ifc.o_mem_addr), 512'(mm.addr));
                    if (mm.wr) begin
                        chk("mem_be", 512'(ifc.o_mem_be), 512'(mm.be));
                        chk("mem_wdata", ifc.o_mem_wdata & bmask(ifc.o_mem_be), mm.data & bmask(mm.be));
                    end
                end
            end else begin
                held = cmd;
                h_rd = ifc.o_mem_rd;
                h_wr = ifc.o_mem_wr;
                h_addr = ifc.o_mem_addr;
                h_wdata = ifc.o_mem_wdata;
                h_be = ifc.o_mem_be;
            end
            if (ifc.o_rbuf_wr_en) begin
                if (rq.size() == 0) chk("rbuf_unexpected", 512'(rq.size()), 512'(1));
                else begin
                    rr = rq.pop_front();
                    chk("rbuf_row", 512'(ifc.o_rbuf_row), 512'(rr.row));
                    chk("rbuf_beat", 512'(ifc.o_rbuf_beat), 512'(rr.beat));
                    chk("rbuf_wdata", ifc.o_rbuf_wdata, rr.data);
                end
            end
            if (ifc.o_making_request) busy_cnt++;
        end
    end
    task automatic expect_xfer(input bit rd, input bit wr, input logic [31:0] ra, input logic [31:0] rs,
                               input logic [31:0] wa, input logic [31:0] ws, input int w, input int h,
                               input bit sel, output int nw);
        int wc, hc, nb;
        logic [31:0] a;
        logic [63:0] be;
        for (int s = 0; s < 2; s++)
            for (int r = 0; r < 10; r++)
                for (int b = 0; b < 8; b++) wbuf[s][r][b] = rnd512();
        wc = (w > 512) ? 512 : w;
        hc = (h > 10) ? 10 : h;
        nb = (wc + 63) / 64;
        nw = 0;
        if (wr && wc > 0 && hc > 0)
            for (int r = 0; r < hc; r++)
                for (int b = 0; b < nb; b++) begin
                    be = (b == nb - 1 && wc % 64 != 0) ? (64'h1 << (wc % 64)) - 64'h1 : '1;
                    a = wa + 32'(r) * ws + 32'(b * 64);
                    mq.push_back('{1'b1, a, wbuf[!sel][r][b], be});
                    nw++;
                end
        if (rd)
            for (int r = 0; r < 10; r++)
                for (int b = 0; b < 8; b++) begin
                    a = ra + 32'(r) * rs + 32'(b * 64);
                    mq.push_back('{1'b0, a, '0, '0});
                    rq.push_back('{4'(r), 3'(b), rd_word(a)});
                end
    endtask
    task automatic request(input bit rd, input bit wr, input logic [31:0] ra, input logic [31:0] rs,
                           input logic [31:0] wa, input logic [31:0] ws, input int w, input int h, input bit sel);
        @(negedge clk);
        ifc.i_req_read = rd;
        ifc.i_req_write = wr;
        ifc.i_read_address = ra;
        ifc.i_rd_stride = rs;
        ifc.i_write_address = wa;
        ifc.i_wr_stride = ws;
        ifc.i_req_width = 16'(w);
        ifc.i_req_height = 8'(h);
        ifc.i_rd_buffer_sel = sel;
        @(posedge clk);
        #1;
        ifc.i_req_read = 1'b0;
        ifc.i_req_write = 1'b0;
        chk("buf_sel", 512'(ifc.o_buf_sel), 512'(!sel));
    endtask
    task automatic run(input bit rd, input bit wr, input logic [31:0] ra, input logic [31:0] rs,
                       input logic [31:0] wa, input logic [31:0] ws, input int w, input int h,
                       input bit sel, input int mw);
        int nw;
        max_wait = mw;
        stray = (mw > 0);
        expect_xfer(rd, wr, ra, rs, wa, ws, w, h, sel, nw);
        busy_cnt = 0;
        request(rd, wr, ra, rs, wa, ws, w, h, sel);
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk);
            #2;
            if (mq.size() == 0 && rq.size() == 0 && !ifc.o_making_request) break;
        end
        chk("xfer_complete", 512'(mq.size() + rq.size()), 512'(0));
        if (mw == 0) chk("busy_cycles", 512'(busy_cnt), 512'(2 * nw + (rd ? 80 : 0)));
        mq.delete();
        rq.delete();
        repeat (2) @(posedge clk);
    endtask
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int nw, rd, wr;
        ifc.i_req_read = 1'b0;
        ifc.i_req_write = 1'b0;
        ifc.i_read_address = '0;
        ifc.i_write_address = '0;
        ifc.i_rd_stride = '0;
        ifc.i_wr_stride = '0;
        ifc.i_req_width = '0;
        ifc.i_req_height = '0;
        ifc.i_rd_buffer_sel = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_making_request", 512'(ifc.o_making_request), 512'(0));
        chk("rst_mem_rd", 512'(ifc.o_mem_rd), 512'(0));
        chk("rst_mem_wr", 512'(ifc.o_mem_wr), 512'(0));
        chk("rst_buf_sel", 512'(ifc.o_buf_sel), 512'(0));
        chk("rst_rbuf_wr_en", 512'(ifc.o_rbuf_wr_en), 512'(0));
        chk("rst_wbuf_rd_en", 512'(ifc.o_wbuf_rd_en), 512'(0));
        chk("rst_mem_addr", 512'(ifc.o_mem_addr), 512'(0));
        chk("rst_mem_be", 512'(ifc.o_mem_be), 512'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run(1, 0, 32'h100, 32'd486, 0, 0, 0, 0, 0, 0);
        run(0, 1, 0, 0, 32'h2000, 32'd484, 150, 8, 1, 0);
        run(1, 1, 32'h4000, 32'd600, 32'h8000, 32'd700, 300, 5, 0, 0);
        run(0, 1, 0, 0, 32'h1_0000, 32'd520, 1000, 20, 1, 0);
        run(1, 1, 32'h300, 32'd512, 32'h9000, 32'd64, 0, 5, 1, 0);
        run(0, 1, 0, 0, 32'hA000, 32'd64, 64, 0, 0, 0);
        run(1, 1, 32'hFFFF_FF00, 32'hFFFF_F000, 32'hFFFF_FFC0, 32'h0000_1000, 512, 10, 0, 0);
        for (int t = 0; t < 6; t++) begin
            rd = int'($urandom_range(0, 1));
            wr = int'($urandom_range(0, 1));
            if (rd == 0 && wr == 0) rd = 1;
            run(rd[0], wr[0], $urandom, $urandom_range(0, 4096), $urandom, $urandom_range(0, 4096),
                int'($urandom_range(0, 600)), int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), 20);
        end
        max_wait = 3;
        stray = 1;
        expect_xfer(1, 0, 32'h5000, 32'd640, 0, 0, 0, 0, 0, nw);
        request(1, 0, 32'h5000, 32'd640, 0, 0, 0, 0, 0);
        for (int c = 0; c < 5000 && rq.size() > 60; c++) @(negedge clk);
        chk("reset_point_reached", 512'(rq.size() <= 60), 512'(1));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_rd", 512'(ifc.o_mem_rd), 512'(0));
        chk("midrst_making_request", 512'(ifc.o_making_request), 512'(0));
        chk("midrst_rbuf_wr_en", 512'(ifc.o_rbuf_wr_en), 512'(0));
        mq.delete();
        rq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run(1, 0, 32'h6000, 32'd700, 0, 0, 0, 0, 1, 0);
        run(1, 1, 32'h7000, 32'd1024, 32'hC000, 32'd256, 200, 3, 0, 20);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
